// File: rtl/load_align_unit.sv
// Load-alignment unit: accepts one load, issues one or two aligned word
// reads, merges the beats, then extracts and extends the addressed bytes
// for writeback together with the destination tag.
module load_align_unit #(
    parameter int XLEN           = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [2:0]      ld_type,
    input  logic [4:0]      ld_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_err
);

    localparam int BYTES = XLEN / 8;
    localparam int OFS   = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    // Decoded view of the request currently on the ld_* inputs
    logic [3:0]     size_in;
    logic           sign_in;
    logic           illegal_in;
    logic [OFS-1:0] ofs_in;
    logic           cross_in;
    logic           fail_in;

    // Captured request attributes, valid from accept until DONE
    logic [3:0]      size_q;
    logic            sign_q;
    logic [OFS-1:0]  ofs_q;
    logic            cross_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] beat0_q;

    // Merge / extract datapath
    logic [XLEN-1:0]   beat_lo;
    logic [XLEN-1:0]   beat_hi;
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   ext;
    logic              sbit;
    int                nbits;

    // Size, signedness and legality of the incoming load type
    always_comb begin
        size_in    = 4'd1;
        sign_in    = 1'b0;
        illegal_in = 1'b0;
        case (ld_type)
            3'b000: begin size_in = 4'd1; sign_in = 1'b1; end
            3'b001: begin size_in = 4'd2; sign_in = 1'b1; end
            3'b010: begin size_in = 4'd4; sign_in = 1'b1; end
            3'b011: size_in = 4'd1;
            3'b100: size_in = 4'd2;
            3'b101: begin size_in = 4'd4; illegal_in = (XLEN == 32); end
            3'b110: begin size_in = 4'd8; illegal_in = (XLEN == 32); end
            default: illegal_in = 1'b1;
        endcase
    end

    assign ofs_in   = ld_addr[OFS-1:0];
    // 5 bits hold the worst case offset+size (7 + 8)
    assign cross_in = (5'(ofs_in) + 5'(size_in)) > 5'(BYTES);
    assign fail_in  = illegal_in | (cross_in & ~ALLOW_MISALIGN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; a failing request skips memory entirely
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ld_valid)      state_nx = fail_in ? DONE : REQ0;
            REQ0:    if (mem_req_ready) state_nx = WAIT0;
            WAIT0:   if (mem_rsp_valid) state_nx = cross_q ? REQ1 : DONE;
            REQ1:    if (mem_req_ready) state_nx = WAIT1;
            WAIT1:   if (mem_rsp_valid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ld_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ0) || (state == REQ1);

    // Merge the beats and extend the addressed bytes. The final beat is
    // taken straight off mem_rsp_data so the result registers on the same
    // edge that the response is consumed.
    always_comb begin
        beat_lo = (state == WAIT1) ? beat0_q : mem_rsp_data;
        beat_hi = (state == WAIT1) ? mem_rsp_data : '0;
        merged  = {beat_hi, beat_lo} >> {ofs_q, 3'b000};
        case (size_q)
            4'd1:    begin nbits = 8;    sbit = merged[7];      end
            4'd2:    begin nbits = 16;   sbit = merged[15];     end
            4'd4:    begin nbits = 32;   sbit = merged[31];     end
            default: begin nbits = XLEN; sbit = merged[XLEN-1]; end
        endcase
        ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < nbits) ext[i] = merged[i];
            else           ext[i] = sign_q & sbit;
        end
    end

    // Request capture, memory address sequencing and writeback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q       <= 4'd1;
            sign_q       <= 1'b0;
            ofs_q        <= '0;
            cross_q      <= 1'b0;
            rd_q         <= 5'd0;
            beat0_q      <= '0;
            mem_req_addr <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= 5'd0;
            wb_err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        size_q       <= size_in;
                        sign_q       <= sign_in;
                        ofs_q        <= ofs_in;
                        cross_q      <= cross_in;
                        rd_q         <= ld_rd;
                        mem_req_addr <= {ld_addr[XLEN-1:OFS], {OFS{1'b0}}};
                        if (fail_in) begin
                            wb_valid <= 1'b1;
                            wb_data  <= '0;
                            wb_err   <= 1'b1;
                            wb_rd    <= ld_rd;
                        end
                    end
                end
                WAIT0: begin
                    if (mem_rsp_valid) begin
                        beat0_q <= mem_rsp_data;
                        if (cross_q) begin
                            // next word; wraps naturally at the top of memory
                            mem_req_addr <= mem_req_addr + XLEN'(BYTES);
                        end else begin
                            wb_valid <= 1'b1;
                            wb_data  <= ext;
                            wb_err   <= 1'b0;
                            wb_rd    <= rd_q;
                        end
                    end
                end
                WAIT1: begin
                    if (mem_rsp_valid) begin
                        wb_valid <= 1'b1;
                        wb_data  <= ext;
                        wb_err   <= 1'b0;
                        wb_rd    <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
